// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the 5-stage RV32 pipe: load-use bubbles, EX redirects, flush runs, dmem wait.
// Define HAZARD_PERF_CNT_EN to add stall/flush performance counters with a synchronous clear.
module hazard_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_W        = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [4:0]      ex_rd,
  input  logic            ex_mem_read,
  input  logic            ex_branch_taken,
  input  logic [XLEN-1:0] ex_branch_target,
  input  logic            dmem_busy,
`ifdef HAZARD_PERF_CNT_EN
  input  logic            perf_clr,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt,
`endif
  output logic            pc_stall,
  output logic            ifid_stall,
  output logic            ifid_flush,
  output logic            idex_stall,
  output logic            idex_flush,
  output logic            pipe_freeze,
  output logic            pc_redirect,
  output logic [XLEN-1:0] redirect_target,
  output logic            mem_timeout
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;

  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] BUSY_MAX   = CNT_W'(MEM_TIMEOUT);

  logic [1:0]      state_q, state_d;
  logic            pending_q, pending_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic            timeout_q, timeout_d;

  logic            load_use;
  logic            resolve;
  logic            br_go;
  logic [XLEN-1:0] br_tgt;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Counts consecutive busy cycles regardless of state; saturates at the timeout threshold.
  assign busy_cnt_d = !dmem_busy ? '0 :
                      (busy_cnt_q == BUSY_MAX) ? busy_cnt_q : busy_cnt_q + 1'b1;
  assign timeout_d  = timeout_q || (busy_cnt_d == BUSY_MAX);
  assign mem_timeout = timeout_q;

  always_comb begin
    state_d         = state_q;
    pending_d       = pending_q;
    target_d        = target_q;
    fcnt_d          = fcnt_q;
    pc_stall        = 1'b0;
    ifid_stall      = 1'b0;
    ifid_flush      = 1'b0;
    idex_stall      = 1'b0;
    idex_flush      = 1'b0;
    pipe_freeze     = 1'b0;
    pc_redirect     = 1'b0;
    redirect_target = target_q;
    resolve         = 1'b0;
    br_go           = 1'b0;
    br_tgt          = ex_branch_target;

    case (state_q)
      RUN: begin
        if (dmem_busy) begin
          pipe_freeze = 1'b1;
          state_d     = MEM_WAIT;
          if (ex_branch_taken) begin
            pending_d = 1'b1;
            target_d  = ex_branch_target;
          end
        end else begin
          resolve = 1'b1;
          br_go   = ex_branch_taken;
        end
      end
      MEM_WAIT: begin
        // EX is held while frozen, so a fresh taken pulse here is stale.
        if (dmem_busy) begin
          pipe_freeze = 1'b1;
        end else begin
          resolve   = 1'b1;
          br_go     = pending_q || ex_branch_taken;
          br_tgt    = pending_q ? target_q : ex_branch_target;
          pending_d = 1'b0;
          state_d   = RUN;
        end
      end
      FLUSH: begin
        if (dmem_busy) begin
          pipe_freeze = 1'b1;
        end else begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (fcnt_q == CNT_W'(1)) state_d = RUN;
          else                     fcnt_d  = fcnt_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    // Redirect wins over load-use: the ID instruction is wrong-path.
    if (resolve) begin
      if (br_go) begin
        pc_redirect     = 1'b1;
        ifid_flush      = 1'b1;
        idex_flush      = 1'b1;
        redirect_target = br_tgt;
        target_d        = br_tgt;
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_INIT;
        end
      end else if (load_use) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_stall = 1'b1;
      end
    end

    if (!rst_n) begin
      pc_stall        = 1'b0;
      ifid_stall      = 1'b0;
      ifid_flush      = 1'b0;
      idex_stall      = 1'b0;
      idex_flush      = 1'b0;
      pipe_freeze     = 1'b0;
      pc_redirect     = 1'b0;
      redirect_target = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pending_q  <= 1'b0;
      target_q   <= '0;
      fcnt_q     <= '0;
      busy_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      target_q   <= target_d;
      fcnt_q     <= fcnt_d;
      busy_cnt_q <= busy_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else if (perf_clr) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (pc_stall || pipe_freeze) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (idex_flush)              perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1 and 3 flush cycles, timeout 8) against a cycle model.
module tb_hazard_ctrl;

  localparam int MT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, dmem_busy;
  logic [31:0] ex_branch_target;

  logic [1:0]  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic [1:0]  pipe_freeze, pc_redirect, mem_timeout;
  logic [31:0] rt [2];

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state per instance: remaining extra flush cycles, busy run length, pending redirect.
  int          fcs [2] = '{1, 3};
  int          flush_left [2];
  int          busy_run [2];
  bit          pend [2];
  bit          tmo [2];
  logic [31:0] tgt [2];

  always #5 clk = ~clk;

  hazard_ctrl #(.XLEN(32), .FLUSH_CYCLES(1), .MEM_TIMEOUT(MT), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target), .dmem_busy(dmem_busy),
    .pc_stall(pc_stall[0]), .ifid_stall(ifid_stall[0]), .ifid_flush(ifid_flush[0]),
    .idex_stall(idex_stall[0]), .idex_flush(idex_flush[0]), .pipe_freeze(pipe_freeze[0]),
    .pc_redirect(pc_redirect[0]), .redirect_target(rt[0]), .mem_timeout(mem_timeout[0])
  );

  hazard_ctrl #(.XLEN(32), .FLUSH_CYCLES(3), .MEM_TIMEOUT(MT), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target), .dmem_busy(dmem_busy),
    .pc_stall(pc_stall[1]), .ifid_stall(ifid_stall[1]), .ifid_flush(ifid_flush[1]),
    .idex_stall(idex_stall[1]), .idex_flush(idex_flush[1]), .pipe_freeze(pipe_freeze[1]),
    .pc_redirect(pc_redirect[1]), .redirect_target(rt[1]), .mem_timeout(mem_timeout[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    ex_branch_target = 32'd0; dmem_busy = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Model evaluation and per-cycle comparison, on the inactive edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit          e_ps, e_is, e_if, e_xs, e_xf, e_fz, e_rd, e_to, lu, in_flush, in_wait, br;
      logic [31:0] e_rt, t;
      e_ps = 0; e_is = 0; e_if = 0; e_xs = 0; e_xf = 0; e_fz = 0; e_rd = 0;
      e_to = tmo[i];
      e_rt = tgt[i];
      lu = ex_mem_read && ex_rd != 0 &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      if (!rst_n) begin
        flush_left[i] = 0; busy_run[i] = 0; pend[i] = 0; tmo[i] = 0; tgt[i] = 0;
        e_to = 0; e_rt = 0;
      end else begin
        in_flush = flush_left[i] > 0;
        in_wait  = !in_flush && busy_run[i] > 0;
        if (dmem_busy) begin
          e_fz = 1;
          if (!in_flush && !in_wait && ex_branch_taken) begin
            pend[i] = 1;
            tgt[i]  = ex_branch_target;
          end
        end else if (in_flush) begin
          e_if = 1; e_xf = 1;
          flush_left[i]--;
        end else begin
          br = pend[i] || ex_branch_taken;
          t  = pend[i] ? tgt[i] : ex_branch_target;
          pend[i] = 0;
          if (br) begin
            e_rd = 1; e_if = 1; e_xf = 1; e_rt = t;
            tgt[i] = t;
            flush_left[i] = fcs[i] - 1;
          end else if (lu) begin
            e_ps = 1; e_is = 1; e_xs = 1;
          end
        end
        busy_run[i] = dmem_busy ? ((busy_run[i] < MT) ? busy_run[i] + 1 : MT) : 0;
        if (busy_run[i] >= MT) tmo[i] = 1;
      end
      chk($sformatf("u%0d.pc_stall", i), 32'(pc_stall[i]), 32'(e_ps));
      chk($sformatf("u%0d.ifid_stall", i), 32'(ifid_stall[i]), 32'(e_is));
      chk($sformatf("u%0d.ifid_flush", i), 32'(ifid_flush[i]), 32'(e_if));
      chk($sformatf("u%0d.idex_stall", i), 32'(idex_stall[i]), 32'(e_xs));
      chk($sformatf("u%0d.idex_flush", i), 32'(idex_flush[i]), 32'(e_xf));
      chk($sformatf("u%0d.pipe_freeze", i), 32'(pipe_freeze[i]), 32'(e_fz));
      chk($sformatf("u%0d.pc_redirect", i), 32'(pc_redirect[i]), 32'(e_rd));
      chk($sformatf("u%0d.redirect_target", i), rt[i], e_rt);
      chk($sformatf("u%0d.mem_timeout", i), 32'(mem_timeout[i]), 32'(e_to));
    end
  end

  int burst;

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    chk("rst.u0.pc_redirect", 32'(pc_redirect[0]), 32'd0);
    chk("rst.u1.redirect_target", rt[1], 32'd0);
    chk("rst.u0.pipe_freeze", 32'(pipe_freeze[0]), 32'd0);
    chk("rst.u1.mem_timeout", 32'(mem_timeout[1]), 32'd0);
    next_cycle();
    rst_n = 1'b1;

    // Load-use on x5 via rs1: one bubble cycle, then the load has moved on.
    ex_rd = 5'd5; ex_mem_read = 1'b1; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    @(negedge clk);
    chk("lu.pc_stall", 32'(pc_stall[0]), 32'd1);
    chk("lu.ifid_stall", 32'(ifid_stall[0]), 32'd1);
    chk("lu.idex_stall", 32'(idex_stall[0]), 32'd1);
    next_cycle();
    idle();
    @(negedge clk);
    chk("lu.after.pc_stall", 32'(pc_stall[0]), 32'd0);
    next_cycle();
    ex_rd = 5'd0; ex_mem_read = 1'b1; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    @(negedge clk);
    chk("lu.x0.pc_stall", 32'(pc_stall[0]), 32'd0);

    // Taken branch to 0x100.
    next_cycle();
    idle();
    ex_branch_taken = 1'b1; ex_branch_target = 32'h100;
    @(negedge clk);
    chk("br.u0.pc_redirect", 32'(pc_redirect[0]), 32'd1);
    chk("br.u0.redirect_target", rt[0], 32'h100);
    chk("br.u0.ifid_flush", 32'(ifid_flush[0]), 32'd1);
    chk("br.u0.idex_flush", 32'(idex_flush[0]), 32'd1);
    chk("br.u1.pc_redirect", 32'(pc_redirect[1]), 32'd1);
    next_cycle();
    idle();
    @(negedge clk);
    chk("br.c2.u0.pc_redirect", 32'(pc_redirect[0]), 32'd0);
    chk("br.c2.u0.ifid_flush", 32'(ifid_flush[0]), 32'd0);
    chk("br.c2.u1.ifid_flush", 32'(ifid_flush[1]), 32'd1);
    chk("br.c2.u1.pc_redirect", 32'(pc_redirect[1]), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("br.c3.u1.idex_flush", 32'(idex_flush[1]), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("br.c4.u1.ifid_flush", 32'(ifid_flush[1]), 32'd0);

    // Branch arrives with dmem_busy; redirect deferred until busy drops.
    next_cycle();
    dmem_busy = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 32'h200;
    @(negedge clk);
    chk("mw.c1.pipe_freeze", 32'(pipe_freeze[0]), 32'd1);
    chk("mw.c1.pc_redirect", 32'(pc_redirect[0]), 32'd0);
    for (int k = 2; k <= 4; k++) begin
      next_cycle();
      ex_branch_taken = 1'b0; ex_branch_target = 32'hdead;
      @(negedge clk);
      chk($sformatf("mw.c%0d.pipe_freeze", k), 32'(pipe_freeze[0]), 32'd1);
    end
    next_cycle();
    dmem_busy = 1'b0;
    @(negedge clk);
    chk("mw.c5.pc_redirect", 32'(pc_redirect[0]), 32'd1);
    chk("mw.c5.redirect_target", rt[0], 32'h200);
    chk("mw.c5.idex_flush", 32'(idex_flush[0]), 32'd1);
    chk("mw.c5.pipe_freeze", 32'(pipe_freeze[0]), 32'd0);
    next_cycle();
    idle();
    repeat (3) next_cycle();

    // Branch and load-use together: redirect only.
    ex_branch_taken = 1'b1; ex_branch_target = 32'h300;
    ex_rd = 5'd7; ex_mem_read = 1'b1; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    @(negedge clk);
    chk("brlu.idex_stall", 32'(idex_stall[0]), 32'd0);
    chk("brlu.idex_flush", 32'(idex_flush[0]), 32'd1);
    chk("brlu.pc_stall", 32'(pc_stall[0]), 32'd0);
    next_cycle();
    idle();
    repeat (3) next_cycle();

    // Busy for 10 cycles: flag registers at the edge ending the 8th busy cycle.
    for (int k = 1; k <= 10; k++) begin
      dmem_busy = 1'b1;
      @(negedge clk);
      if (k == 8) chk("tmo.c8", 32'(mem_timeout[0]), 32'd0);
      if (k == 9) chk("tmo.c9", 32'(mem_timeout[0]), 32'd1);
      next_cycle();
    end
    dmem_busy = 1'b0;
    @(negedge clk);
    chk("tmo.sticky", 32'(mem_timeout[0]), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("tmo.async_clear", 32'(mem_timeout[0]), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Randomized phase with bursty memory waits and occasional resets.
    burst = 0;
    for (int c = 0; c < 800; c++) begin
      next_cycle();
      id_rs1      = 5'($urandom_range(0, 6));
      id_rs2      = 5'($urandom_range(0, 6));
      ex_rd       = 5'($urandom_range(0, 6));
      id_uses_rs1 = ($urandom_range(0, 9) < 7);
      id_uses_rs2 = ($urandom_range(0, 9) < 5);
      ex_mem_read = ($urandom_range(0, 1) == 1);
      ex_branch_taken  = ($urandom_range(0, 99) < 15);
      ex_branch_target = $urandom;
      if (burst == 0 && $urandom_range(0, 99) < 8) burst = $urandom_range(1, 12);
      dmem_busy = (burst > 0);
      if (burst > 0) burst--;
      rst_n = !($urandom_range(0, 199) == 0);
    end
    next_cycle();
    rst_n = 1'b1;
    idle();
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard sequencer for the 5-stage RV32 core.
- Generates the stall, flush and freeze controls for PC, IF/ID and ID/EX, and drives the stall/flush inputs of the decode control mux.
- Covers load-use bubbles, taken-branch/jump redirects resolved in EX, multi-cycle flush sequences and data-memory wait, with a redirect held pending across memory stalls.

Parameters:
- XLEN, 32, width of branch target / redirect address.
- FLUSH_CYCLES, 1, cycles IF/ID and ID/EX are flushed per redirect (legal 1..4).
- MEM_TIMEOUT, 255, consecutive dmem_busy cycles before mem_timeout sets.
- CNT_W, 8, width of flush and busy counters (must hold MEM_TIMEOUT).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1  in  5  rs1 of instruction in ID.
- id_rs2  in  5  rs2 of instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  destination register of instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch/jump (1-cycle pulse).
- ex_branch_target  in  XLEN  redirect address, valid with ex_branch_taken.
- dmem_busy  in  1  data memory not ready; whole pipe must hold.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  zero IF/ID.
- idex_stall  out  1  bubble into ID/EX (decode mux stall).
- idex_flush  out  1  zero ID/EX (decode mux flush).
- pipe_freeze  out  1  freeze all stage registers.
- pc_redirect  out  1  load PC from redirect_target this cycle.
- redirect_target  out  XLEN  PC to load.
- mem_timeout  out  1  sticky error flag.

Behaviour:
- Reset: state=RUN, pending=0, redirect_target=0, counters=0, mem_timeout=0. All other outputs are 0 while rst_n is low.
- Load-use condition (LU): ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
- Outputs are combinational from state + inputs; state, pending and counters are registered.
- State RUN, priority high to low:
  - dmem_busy: pipe_freeze=1, all others 0. If ex_branch_taken is also asserted, set pending=1 and capture redirect_target=ex_branch_target. Next state MEM_WAIT, busy_cnt=1.
  - Else ex_branch_taken: pc_redirect=1, ifid_flush=1, idex_flush=1. redirect_target shows ex_branch_target combinationally and registers it. If FLUSH_CYCLES>1, go FLUSH with fcnt=FLUSH_CYCLES-1; otherwise stay in RUN.
  - Else LU: pc_stall=1, ifid_stall=1, idex_stall=1 for one cycle. No state change; the hazard clears as the load advances.
  - A redirect overrides LU in the same cycle, because the ID instruction is wrong-path.
- State MEM_WAIT:
  - While dmem_busy: pipe_freeze=1 and busy_cnt saturates. When busy_cnt==MEM_TIMEOUT, mem_timeout sets and remains set until reset. Waiting continues.
  - A new ex_branch_taken while frozen is ignored, because EX is held.
  - When dmem_busy=0: evaluate exactly as RUN with branch = pending || ex_branch_taken, using the registered target when pending. Clear pending and busy_cnt.
- State FLUSH:
  - ifid_flush=1, idex_flush=1, pc_redirect=0, pc free-running.
  - fcnt decrements each cycle; return to RUN on the cycle fcnt==1.
  - ex_branch_taken and LU are ignored, because the EX/ID contents are bubbles.
  - If dmem_busy asserts: pipe_freeze=1, flush outputs 0, fcnt holds; resume when busy drops. busy_cnt and timeout apply as in MEM_WAIT.
- Stall and flush on the same register never assert together.
- Reset mid-sequence aborts any pending redirect.

Optional Feature:
- HAZARD_PERF_CNT_EN defined: adds 32-bit outputs perf_stall_cnt (cycles with pc_stall or pipe_freeze) and perf_flush_cnt (cycles with idex_flush). Both wrap at 2^32, reset to 0, and clear synchronously on a new input perf_clr.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Load x5 in EX (ex_rd=5, ex_mem_read=1), ID uses rs1=5 -> pc_stall=ifid_stall=idex_stall=1 for exactly 1 cycle. With ex_rd=0 -> no stall.
- ex_branch_taken pulse, target 0x0000_0100, FLUSH_CYCLES=1 -> same cycle: pc_redirect=1, redirect_target=0x100, ifid_flush=idex_flush=1. Next cycle all 0.
- FLUSH_CYCLES=3, branch -> flush asserted 3 consecutive cycles; pc_redirect only in the first.
- dmem_busy and branch (target 0x200) in the same cycle, busy held 4 cycles -> pipe_freeze=1 for 4 cycles, then pc_redirect=1 with target 0x200 plus flush on cycle 5.
- Branch and LU in the same cycle -> flush/redirect only, idex_stall=0.
- MEM_TIMEOUT=8, dmem_busy held 10 cycles -> mem_timeout rises at the 8th busy cycle and stays 1 after busy drops, until rst_n is pulsed low (async, mid-clock).
